// File: rtl/fifo_drain.sv
// fifo_drain: pops words from the sample fifo head and streams them to the
// host link as little-endian bytes over valid/ready. A two-byte sync marker
// follows every SYNC_PERIOD words so the host can realign the byte stream.
module fifo_drain #(
    parameter int          WIDTH       = 40,       // fifo word width, at least 16
    parameter int          SYNC_PERIOD = 256,      // words between markers, 0 = never
    parameter logic [15:0] SYNC_WORD   = 16'h5AA5  // marker, low byte first
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic [WIDTH-1:0] out,
    input  logic             oute,
    output logic             adv,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int SW    = BYTES * 8;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES - 1);
    localparam logic [IW-1:0] SYNC_LAST = IW'(1);
    localparam logic [CW-1:0] SYNC_MAX  = CW'(SYNC_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        SYNC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] sync_cnt_q, sync_cnt_d;
    logic [15:0]   words_q, words_d;
    logic          adv_q, adv_d;
    logic          tx_valid_q, tx_valid_d;

    logic          handshake;
    logic [CW-1:0] sync_inc;

    assign handshake = tx_valid_q && tx_ready;
    assign sync_inc  = sync_cnt_q + CW'(1);

    // Next-state logic: the shift register doubles as the byte source for
    // both data words and the sync marker, so tx_data is always its low byte
    // and drains to zero once the last byte of either has been accepted.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        sync_cnt_d = sync_cnt_q;
        words_d    = words_q;
        adv_d      = 1'b0;
        tx_valid_d = tx_valid_q;

        case (state_q)
            IDLE: begin
                if (oute) begin
                    adv_d      = 1'b1;
                    shift_d    = SW'(out);
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end

            SEND: begin
                if (handshake) begin
                    shift_d = shift_q >> 8;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        words_d    = words_q + 16'd1;
                        sync_cnt_d = sync_inc;
                        if ((SYNC_PERIOD != 0) && (sync_inc == SYNC_MAX)) begin
                            // Keep tx_valid high straight into the marker.
                            sync_cnt_d = '0;
                            shift_d    = SW'(SYNC_WORD);
                            idx_d      = '0;
                            state_d    = SYNC;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
            end

            SYNC: begin
                if (handshake) begin
                    shift_d = shift_q >> 8;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == SYNC_LAST) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything, including a word
    // that has already been popped from the fifo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            sync_cnt_q <= '0;
            words_q    <= '0;
            adv_q      <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            sync_cnt_q <= sync_cnt_d;
            words_q    <= words_d;
            adv_q      <= adv_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign adv        = adv_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = shift_q[7:0];
    assign busy       = (state_q != IDLE);
    assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a fifo model feeds each DUT, stimulus pushes words
// plus their expected bytes, and a monitor per DUT pops the expected queue on
// every accepted byte. dut uses the default sync period, dut2 uses 2.
module tb_fifo_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [39:0] out = '0;
    logic        oute = 1'b0;
    logic        adv;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] words_sent;

    logic [39:0] out2 = '0;
    logic        oute2 = 1'b0;
    logic        adv2;
    logic [7:0]  tx_data2;
    logic        tx_valid2;
    logic        tx_ready2 = 1'b0;
    logic        busy2;
    logic [15:0] words_sent2;

    logic [39:0] fifo_q[$];
    logic [39:0] fifo2_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp2_q[$];

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int adv_cnt = 0;
    int adv2_cnt = 0;

    always #5 clk = ~clk;

    fifo_drain dut (
        .clk        (clk),
        .reset      (reset),
        .out        (out),
        .oute       (oute),
        .adv        (adv),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .words_sent (words_sent)
    );

    fifo_drain #(.SYNC_PERIOD(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .out        (out2),
        .oute       (oute2),
        .adv        (adv2),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .busy       (busy2),
        .words_sent (words_sent2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Fifo models: pop on adv, then present the new head.
    always begin
        @(posedge clk);
        #2;
        if (adv && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (adv2 && fifo2_q.size() > 0) void'(fifo2_q.pop_front());
        oute  = (fifo_q.size() > 0);
        out   = (fifo_q.size() > 0) ? fifo_q[0] : 40'h0;
        oute2 = (fifo2_q.size() > 0);
        out2  = (fifo2_q.size() > 0) ? fifo2_q[0] : 40'h0;
    end

    // Monitors: every accepted byte is compared against the scoreboard.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (adv) adv_cnt++;
        if (adv2) adv2_cnt++;
        if (reset && tx_valid && tx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_extra: got %h required none", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("byte", 64'(tx_data), 64'(e));
                $display("byte %h expected %h", tx_data, e);
            end
        end
        if (reset && tx_valid2 && tx_ready2) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte2_extra: got %h required none", tx_data2);
            end else begin
                e = exp2_q.pop_front();
                check("byte2", 64'(tx_data2), 64'(e));
                $display("byte2 %h expected %h", tx_data2, e);
            end
        end
    end

    task automatic push_word(input logic [39:0] w);
        fifo_q.push_back(w);
        for (int k = 0; k < 5; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic push_word2(input logic [39:0] w);
        fifo2_q.push_back(w);
        for (int k = 0; k < 5; k++) exp2_q.push_back(w[8*k +: 8]);
    endtask

    task automatic wait_adv(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (adv) seen = 1'b1;
        end
        check({name, "_adv_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [39:0] w;
        int a0, h0, prev, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_adv", 64'(adv), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_words", 64'(words_sent), 64'(0));
        check("rst_busy2", 64'(busy2), 64'(0));
        reset = 1'b1;

        // 1: single word, bytes on consecutive cycles
        tx_ready = 1'b1;
        a0 = adv_cnt;
        w = 40'h0123456789;
        push_word(w);
        wait_adv("t1");
        check("t1_valid_with_adv", 64'(tx_valid), 64'(1));
        check("t1_byte0", 64'(tx_data), 64'(8'h89));
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t1_byte_seq", 64'(tx_data), 64'(w[8*k +: 8]));
        end
        @(posedge clk);
        #1;
        check("t1_valid_low", 64'(tx_valid), 64'(0));
        check("t1_busy_low", 64'(busy), 64'(0));
        check("t1_words", 64'(words_sent), 64'(1));
        check("t1_adv_pulses", 64'(adv_cnt - a0), 64'(1));
        $display("t1 single word done, words_sent=%0d", words_sent);

        // 2: backpressure on byte 2
        h0 = hs_cnt;
        push_word(40'h0123456789);
        wait_adv("t2");
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t2_hold_data", 64'(tx_data), 64'(8'h45));
            check("t2_hold_valid", 64'(tx_valid), 64'(1));
        end
        tx_ready = 1'b1;
        wait_drain("t2");
        check("t2_handshakes", 64'(hs_cnt - h0), 64'(5));
        check("t2_words", 64'(words_sent), 64'(2));
        $display("t2 backpressure done, handshakes=%0d", hs_cnt - h0);

        // 3: empty fifo
        n = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (adv || tx_valid || busy) n++;
        end
        check("t3_quiet_cycles_bad", 64'(n), 64'(0));
        check("t3_words", 64'(words_sent), 64'(2));
        $display("t3 empty fifo done");

        // 4: sync insertion on dut2 (period 2)
        tx_ready2 = 1'b1;
        push_word2(40'h1);
        push_word2(40'h2);
        exp2_q.push_back(8'hA5);
        exp2_q.push_back(8'h5A);
        push_word2(40'h3);
        for (int i = 0; i < 300 && (exp2_q.size() != 0 || busy2); i++) begin
            @(posedge clk);
            #1;
        end
        check("t4_drained", 64'(exp2_q.size()), 64'(0));
        check("t4_adv_pulses", 64'(adv2_cnt), 64'(3));
        check("t4_words", 64'(words_sent2), 64'(3));
        $display("t4 sync insertion done, adv2=%0d", adv2_cnt);

        // 5: reset after byte 1 handshake
        fifo_q.push_back(40'hAABBCCDDEE);
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'hDD);
        push_word(40'h1122334455);
        wait_adv("t5a");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t5_valid_async", 64'(tx_valid), 64'(0));
        check("t5_adv_async", 64'(adv), 64'(0));
        check("t5_words_cleared", 64'(words_sent), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_adv("t5b");
        check("t5_restart_byte0", 64'(tx_data), 64'(8'h55));
        wait_drain("t5");
        check("t5_words", 64'(words_sent), 64'(1));
        $display("t5 reset mid-send done");

        // 6: streaming counter words, adv every 6 cycles
        for (int i = 0; i < 8; i++) push_word(40'hFE + 40'(i));
        prev = 0;
        n = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            @(posedge clk);
            #1;
            if (adv) begin
                if (n > 0) check("t6_adv_gap", 64'(c - prev), 64'(6));
                prev = c;
                n++;
            end
        end
        check("t6_adv_count", 64'(n), 64'(8));
        wait_drain("t6");
        check("t6_words", 64'(words_sent), 64'(9));
        $display("t6 streaming done, words_sent=%0d", words_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
Read side of the sample FIFO. It pops 40-bit capture words from the fifo head (out/oute/adv) and serializes each word into a little-endian byte stream. Bytes go to the host-link byte sink (UART/USB TX) over a valid/ready handshake. A periodic sync marker is inserted so the host can realign the stream.

Parameters:
WIDTH, 40, fifo word width; must be ≥16. BYTES = ceil(WIDTH/8); unused top bits are sent as 0.
SYNC_PERIOD, 256, number of words between sync markers; 0 disables sync insertion.
SYNC_WORD, 16'h5AA5, sync marker; low byte is sent first.

Ports:
clk  in  1  system clock (24 MHz domain).
reset  in  1  asynchronous, active-low reset.
out  in  WIDTH  fifo head word; valid while oute=1.
oute  in  1  fifo non-empty / head valid.
adv  out  1  single-cycle pop strobe to the fifo.
tx_data  out  8  byte to the sink.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
busy  out  1  high in any state other than IDLE.
words_sent  out  16  count of fully transmitted words; wraps modulo 2^16.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: adv=0, tx_valid=0, tx_data=0, busy=0, words_sent=0.
  - Internal: state=IDLE, shift register=0, byte index=0, sync counter=0.
  - Any in-flight word is discarded, including one already popped.
- States: IDLE, SEND, SYNC.
- IDLE, oute=0: hold; adv=0.
- IDLE, oute=1, registered on the clk edge:
  - adv=1 for exactly one cycle.
  - Shift register <= zero-extended out.
  - Byte index <= 0.
  - State -> SEND.
  - tx_valid rises in the same cycle that adv is high; tx_data = out[7:0].
- SEND:
  - tx_data = shift register[7:0]; tx_valid=1.
  - On handshake: shift register >>= 8; byte index += 1.
  - On handshake of byte BYTES-1:
    - words_sent += 1; sync counter += 1.
    - If SYNC_PERIOD≠0 and the sync counter reaches SYNC_PERIOD: counter <= 0, state -> SYNC.
    - Otherwise state -> IDLE and tx_valid drops.
- SYNC:
  - Sends SYNC_WORD[7:0], then SYNC_WORD[15:8], each under the same handshake.
  - After the second handshake, state -> IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops without a handshake, except on reset.
- Throughput: one idle cycle between words. Minimum per word is BYTES+1 cycles, plus 2 cycles when a sync marker follows.
- adv occurs only in IDLE, so oute is never sampled in the cycle after a pop. Because BYTES ≥ 2, the fifo head has always settled before the next IDLE.
- Boundaries:
  - oute dropping mid-SEND has no effect; the word is already latched.
  - tx_ready may be held at 1 permanently.
  - SYNC_PERIOD=1 puts a marker after every word.
  - words_sent wraps 16'hFFFF -> 0.
  - The sync counter is not affected by words_sent wrap.

Test Plan:
1. Single word: out=40'h0123456789, oute=1 for one word, tx_ready=1.
   -> exactly one adv pulse.
   -> tx bytes 89, 67, 45, 23, 01 on consecutive cycles.
   -> words_sent=1, busy falls.
2. Backpressure: tx_ready=0 for 3 cycles while byte 2 (8'h45) is presented.
   -> tx_data stays 8'h45 and tx_valid stays 1 throughout.
   -> no byte is lost or duplicated; total of 5 handshakes.
3. Empty fifo: oute=0 for 100 cycles.
   -> adv=0, tx_valid=0, busy=0, words_sent unchanged.
4. Sync insertion: SYNC_PERIOD=2, fifo preloaded with words 40'h1, 40'h2, 40'h3.
   -> byte stream: 01 00 00 00 00, 02 00 00 00 00, A5 5A, 03 00 00 00 00.
   -> exactly 3 adv pulses.
5. Reset mid-SEND: assert reset after byte 1 handshake.
   -> tx_valid and adv drop immediately (asynchronously); words_sent=0.
   -> after release with oute=1, the next fifo word is sent starting from its byte 0.
6. Streaming with the fifo filled by an incrementing counter and tx_ready=1 continuously:
   -> consecutive adv pulses exactly BYTES+1=6 cycles apart.
   -> decoded words are strictly incrementing by 1.
